// File: rtl/plot_sink_pkg.sv
// Shared types and constants for the pixel-plot sink: FSM state encoding,
// the buffered command layout and the default screen geometry.
package plot_sink_pkg;

   localparam int DEF_WIDTH       = 320;
   localparam int DEF_HEIGHT      = 240;
   localparam int DEF_COLOUR_BITS = 3;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_ADDR_BITS   = 17;

   localparam int SCREEN_PIXELS = DEF_WIDTH * DEF_HEIGHT;
   localparam int LAST_ADDR     = SCREEN_PIXELS - 1;

   // IDLE: nothing buffered, port quiet. DRAIN: presenting buffered plots.
   // CLEAR: sweeping every framebuffer address with the fill colour.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } state_t;

   // One buffered plot command, already converted to a linear address.
   typedef struct packed {
      logic [DEF_ADDR_BITS-1:0]   addr;
      logic [DEF_COLOUR_BITS-1:0] colour;
   } fifo_entry_t;

   // y*320 + x as two shifts and an add, for the default 320-wide screen.
   function automatic logic [DEF_ADDR_BITS-1:0] linear_addr(
      input logic [8:0] px,
      input logic [7:0] py
   );
      logic [DEF_ADDR_BITS-1:0] xe;
      logic [DEF_ADDR_BITS-1:0] ye;
      xe = {8'b0, px};
      ye = {9'b0, py};
      return (ye << 8) + (ye << 6) + xe;
   endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO with show-ahead output. Besides the head entry it
// also exposes the entry behind the head, so a consumer that keeps the head
// in flight until it is acknowledged can line up the next item with no bubble.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module plot_fifo #(
   parameter int DATA_BITS = 20,
   parameter int DEPTH     = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_BITS-1:0]       din,
   output logic [DATA_BITS-1:0]       dout,
   output logic [DATA_BITS-1:0]       dout_next,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   logic [DATA_BITS-1:0] storage [DEPTH];
   logic [PTR_BITS-1:0]  rd_ptr;
   logic [PTR_BITS-1:0]  wr_ptr;
   logic [PTR_BITS-1:0]  rd_ptr_nx;
   logic                 do_push;
   logic                 do_pop;

   assign full      = (count == CNT_BITS'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && (!full || do_pop);
   assign rd_ptr_nx = rd_ptr + PTR_BITS'(1);
   assign dout      = storage[rd_ptr];
   assign dout_next = storage[rd_ptr_nx];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (do_pop)  rd_ptr <= rd_ptr_nx;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) storage[wr_ptr] <= din;
   end

endmodule

// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot interface. Validates plot coordinates,
// buffers accepted plots, converts them to linear framebuffer addresses and
// drives the framebuffer write port. Also runs a full-screen clear sweep.
//
// Memory port handshake: mem_addr/mem_data/mem_valid are registered. A write
// completes on a rising edge where mem_valid && mem_ready; while mem_valid is
// high and mem_ready low, all three outputs hold. A new write may be presented
// in the cycle right after a handshake, so sustained throughput is one write
// per cycle.
//
// A buffered plot stays in the FIFO until its write handshakes, so the FIFO
// occupancy counts the write currently on the port. The FIFO's second entry
// is loaded into the port register on the handshake edge.
module plot_sink
   import plot_sink_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HEIGHT      = DEF_HEIGHT,
   parameter int COLOUR_BITS = DEF_COLOUR_BITS,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [8:0]             x,
   input  logic [7:0]             y,
   input  logic [COLOUR_BITS-1:0] colour,
   input  logic                   plot,
   input  logic                   clear,
   input  logic [COLOUR_BITS-1:0] clear_colour,
   output logic [ADDR_BITS-1:0]   mem_addr,
   output logic [COLOUR_BITS-1:0] mem_data,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic                   busy,
   output logic                   overflow,
   output logic [7:0]             dropped_cnt
);

   localparam int ENTRY_BITS = ADDR_BITS + COLOUR_BITS;
   localparam int CNT_BITS   = $clog2(FIFO_DEPTH) + 1;
   localparam int PIXELS     = WIDTH * HEIGHT;
   localparam logic [ADDR_BITS-1:0] SWEEP_LAST = ADDR_BITS'(PIXELS - 1);

   state_t state;
   state_t state_nx;

   logic                   in_range;
   logic                   plot_ok;
   logic [ADDR_BITS-1:0]   plot_addr;
   logic                   handshake;

   logic                   fifo_push;
   logic                   fifo_pop;
   logic [ENTRY_BITS-1:0]  fifo_din;
   logic [ENTRY_BITS-1:0]  fifo_dout;
   logic [ENTRY_BITS-1:0]  fifo_dout_next;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_BITS-1:0]    fifo_count;

   logic                   clear_pending;
   logic                   pending_nx;
   logic [COLOUR_BITS-1:0] clear_col;
   logic [COLOUR_BITS-1:0] clear_col_nx;
   logic                   valid_nx;
   logic [ADDR_BITS-1:0]   addr_nx;
   logic [COLOUR_BITS-1:0] data_nx;

   assign in_range  = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
   assign plot_ok   = plot && in_range;
   assign handshake = mem_valid && mem_ready;

   // The head entry is the write on the port, so it leaves the FIFO exactly
   // when that write completes; sweep writes never pop.
   assign fifo_pop  = (state == DRAIN) && handshake;
   assign fifo_push = plot_ok && (!fifo_full || fifo_pop);
   assign fifo_din  = {plot_addr, colour};

   generate
      if (WIDTH == DEF_WIDTH && ADDR_BITS == DEF_ADDR_BITS) begin : g_shift_add
         assign plot_addr = linear_addr(x, y);
      end else begin : g_const_mul
         logic [ADDR_BITS-1:0] x_ext;
         logic [ADDR_BITS-1:0] y_ext;
         assign x_ext     = ADDR_BITS'(x);
         assign y_ext     = ADDR_BITS'(y);
         assign plot_addr = y_ext * ADDR_BITS'(WIDTH) + x_ext;
      end
   endgenerate

   plot_fifo #(
      .DATA_BITS (ENTRY_BITS),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .pop       (fifo_pop),
      .din       (fifo_din),
      .dout      (fifo_dout),
      .dout_next (fifo_dout_next),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign busy = (state != IDLE) || (fifo_count != '0) || clear_pending;

   // Next state and next port register contents.
   always_comb begin
      state_nx     = state;
      valid_nx     = mem_valid;
      addr_nx      = mem_addr;
      data_nx      = mem_data;
      pending_nx   = clear_pending;
      clear_col_nx = clear_col;
      case (state)
         IDLE: begin
            // A simultaneous plot is buffered and written after the sweep.
            if (clear) begin
               state_nx     = CLEAR;
               valid_nx     = 1'b1;
               addr_nx      = '0;
               data_nx      = clear_colour;
               clear_col_nx = clear_colour;
            end else if (plot_ok) begin
               state_nx = DRAIN;
               valid_nx = 1'b1;
               addr_nx  = plot_addr;
               data_nx  = colour;
            end
         end
         DRAIN: begin
            if (clear && !clear_pending) begin
               pending_nx   = 1'b1;
               clear_col_nx = clear_colour;
            end
            if (handshake) begin
               if (clear_pending || clear) begin
                  // Remaining buffered plots are drained after the sweep.
                  state_nx   = CLEAR;
                  pending_nx = 1'b0;
                  addr_nx    = '0;
                  data_nx    = clear_pending ? clear_col : clear_colour;
               end else if (fifo_count >= CNT_BITS'(2)) begin
                  {addr_nx, data_nx} = fifo_dout_next;
               end else if (fifo_push) begin
                  {addr_nx, data_nx} = fifo_din;
               end else begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
               end
            end
         end
         CLEAR: begin
            if (handshake) begin
               if (mem_addr == SWEEP_LAST) begin
                  if (!fifo_empty) begin
                     state_nx           = DRAIN;
                     {addr_nx, data_nx} = fifo_dout;
                  end else if (fifo_push) begin
                     state_nx           = DRAIN;
                     {addr_nx, data_nx} = fifo_din;
                  end else begin
                     state_nx = IDLE;
                     valid_nx = 1'b0;
                  end
               end else begin
                  addr_nx = mem_addr + ADDR_BITS'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase
   end

   // FSM state, port register and pending-clear latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         mem_valid     <= 1'b0;
         mem_addr      <= '0;
         mem_data      <= '0;
         clear_pending <= 1'b0;
         clear_col     <= '0;
      end else begin
         state         <= state_nx;
         mem_valid     <= valid_nx;
         mem_addr      <= addr_nx;
         mem_data      <= data_nx;
         clear_pending <= pending_nx;
         clear_col     <= clear_col_nx;
      end
   end

   // Sticky overflow flag and saturating out-of-range drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow    <= 1'b0;
         dropped_cnt <= '0;
      end else begin
         if (plot_ok && fifo_full && !fifo_pop) overflow <= 1'b1;
         if (plot && !in_range && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_plot_sink.sv
// Bench for plot_sink: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-level model of the sink.
module tb_plot_sink;
   import plot_sink_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  x = '0;
   logic [7:0]  y = '0;
   logic [2:0]  colour = '0;
   logic        plot = 1'b0;
   logic        clear = 1'b0;
   logic [2:0]  clear_colour = '0;
   logic        mem_ready = 1'b0;
   logic [16:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_valid;
   logic        busy;
   logic        overflow;
   logic [7:0]  dropped_cnt;

   int vectors = 0;
   int miscompares = 0;

   plot_sink #(
      .WIDTH(320), .HEIGHT(240), .COLOUR_BITS(3), .FIFO_DEPTH(4), .ADDR_BITS(17)
   ) dut (
      .clock(clock), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
      .clear(clear), .clear_colour(clear_colour), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .busy(busy), .overflow(overflow), .dropped_cnt(dropped_cnt)
   );

   // Clock
   always #5 clock = ~clock;

   // Model state: outstanding plots (including the one on the port), sweep progress.
   fifo_entry_t mdl_q[$];
   bit          sweeping = 0;
   bit          pending = 0;
   bit          mdl_ovf = 0;
   bit          mdl_rst = 0;
   bit          started = 0;
   int          pos = 0;
   int          mdl_drops = 0;
   logic [2:0]  sweep_col = '0;
   logic [2:0]  pend_col = '0;
   logic [19:0] act_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model update at each active edge
   always @(posedge clock) begin : model
      bit exp_v, hs, pop, was_sw;
      fifo_entry_t e;
      started = 1;
      mdl_rst = reset;
      if (reset) begin
         mdl_q.delete();
         sweeping = 0; pending = 0; mdl_ovf = 0; mdl_drops = 0; pos = 0;
      end else begin
         exp_v  = sweeping || (mdl_q.size() != 0);
         hs     = exp_v && (mem_ready === 1'b1);
         was_sw = sweeping;
         pop    = hs && !sweeping;
         if (sweeping && hs) begin
            if (pos == LAST_ADDR) sweeping = 0;
            else pos++;
         end
         if (!was_sw) begin
            if (mdl_q.size() == 0) begin
               if (clear) begin sweeping = 1; pos = 0; sweep_col = clear_colour; end
            end else if (pop && (pending || clear)) begin
               sweeping = 1; pos = 0;
               sweep_col = pending ? pend_col : clear_colour;
               pending = 0;
            end else if (clear && !pending) begin
               pending = 1; pend_col = clear_colour;
            end
         end
         if (pop) void'(mdl_q.pop_front());
         if (plot) begin
            if (x < 320 && y < 240) begin
               if (mdl_q.size() < DEF_FIFO_DEPTH) begin
                  e.addr   = 17'(int'(y) * 320 + int'(x));
                  e.colour = colour;
                  mdl_q.push_back(e);
               end else begin
                  mdl_ovf = 1;
               end
            end else if (mdl_drops < 255) begin
               mdl_drops++;
            end
         end
      end
   end

   // Compare DUT against model away from the active edge; log completed writes.
   always @(negedge clock) begin : compare
      bit exp_v;
      int ea, ed;
      if (started) begin
         exp_v = sweeping || (mdl_q.size() != 0);
         chk("mem_valid", 32'(mem_valid), 32'(exp_v));
         if (exp_v) begin
            ea = sweeping ? pos : int'(mdl_q[0].addr);
            ed = sweeping ? int'(sweep_col) : int'(mdl_q[0].colour);
            chk("mem_addr", 32'(mem_addr), ea);
            chk("mem_data", 32'(mem_data), ed);
         end
         if (mdl_rst) begin
            chk("reset_addr", 32'(mem_addr), 0);
            chk("reset_data", 32'(mem_data), 0);
         end
         chk("busy", 32'(busy), 32'(exp_v || pending));
         chk("overflow", 32'(overflow), 32'(mdl_ovf));
         chk("dropped_cnt", 32'(dropped_cnt), mdl_drops);
         if (mem_valid === 1'b1 && mem_ready === 1'b1 && !reset)
            act_log.push_back({mem_addr, mem_data});
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_plot(input int px, input int py, input int pc);
      x = 9'(px); y = 8'(py); colour = 3'(pc); plot = 1'b1;
      tick();
      plot = 1'b0;
   endtask

   // Stimulus
   initial begin : stim
      int bad;
      reset = 1'b1; mem_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(mem_valid), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_dropped", 32'(dropped_cnt), 0);
      reset = 1'b0; mem_ready = 1'b1;
      tick();

      // Single plot: address 2*320+5 = 645, one cycle later
      act_log.delete();
      do_plot(5, 2, 3'b101);
      chk("single_valid", 32'(mem_valid), 1);
      chk("single_addr", 32'(mem_addr), 645);
      chk("single_data", 32'(mem_data), 5);
      chk("single_busy", 32'(busy), 1);
      tick();
      chk("single_after_valid", 32'(mem_valid), 0);
      chk("single_after_busy", 32'(busy), 0);
      repeat (3) tick();
      chk("single_count", act_log.size(), 1);
      if (act_log.size() > 0) chk("single_log", act_log[0], {17'd645, 3'd5});

      // Out-of-range plots
      do_plot(320, 0, 1);
      do_plot(0, 240, 2);
      repeat (3) tick();
      chk("oor_dropped", 32'(dropped_cnt), 2);
      chk("oor_overflow", 32'(overflow), 0);
      chk("oor_writes", act_log.size(), 1);

      // Stalled port: 6 plots, only 4 fit
      mem_ready = 1'b0;
      act_log.delete();
      for (int i = 0; i < 6; i++) do_plot(10 + i, 20 + i, i + 1);
      chk("stall_overflow", 32'(overflow), 1);
      chk("stall_addr", 32'(mem_addr), 6410);
      chk("stall_data", 32'(mem_data), 1);
      repeat (5) tick();
      chk("stall_hold_valid", 32'(mem_valid), 1);
      chk("stall_hold_addr", 32'(mem_addr), 6410);
      chk("stall_hold_data", 32'(mem_data), 1);
      mem_ready = 1'b1;
      repeat (8) tick();
      chk("stall_writes", act_log.size(), 4);
      for (int i = 0; i < 4 && i < act_log.size(); i++)
         chk("stall_order", act_log[i], {17'((20 + i) * 320 + 10 + i), 3'(i + 1)});

      // Drop counter saturation
      for (int i = 0; i < 260; i++) do_plot(320 + (i % 100), 0, 0);
      chk("drop_saturate", 32'(dropped_cnt), 255);

      // Full clear sweep with a plot arriving mid-sweep
      act_log.delete();
      clear_colour = 3'b000; clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (30000) tick();
      chk("clear_mid_busy", 32'(busy), 1);
      do_plot(319, 239, 6);
      for (int i = 0; i < 80000 && busy !== 1'b0; i++) tick();
      chk("clear_done", 32'(busy), 0);
      chk("clear_writes", act_log.size(), 76801);
      bad = 0;
      for (int i = 0; i < 76800 && i < act_log.size(); i++)
         if (act_log[i] !== {17'(i), 3'b000}) bad++;
      chk("clear_order_bad", bad, 0);
      if (act_log.size() == 76801) chk("clear_plot_after", act_log[76800], {17'd76799, 3'd6});

      // Reset in the middle of a sweep at address 1000
      act_log.delete();
      clear_colour = 3'b111; clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < 2000 && !(mem_valid === 1'b1 && mem_addr == 17'd1000); i++) tick();
      chk("sweep_reach_1000", 32'(mem_addr), 1000);
      reset = 1'b1;
      tick();
      chk("abort_valid", 32'(mem_valid), 0);
      chk("abort_addr", 32'(mem_addr), 0);
      chk("abort_data", 32'(mem_data), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_overflow", 32'(overflow), 0);
      chk("abort_dropped", 32'(dropped_cnt), 0);
      reset = 1'b0;
      repeat (10) tick();
      chk("abort_writes", act_log.size(), 1000);
      chk("abort_quiet", 32'(mem_valid), 0);

      // Randomized traffic; long sweeps are cut short by reset
      for (int i = 0; i < 2500; i++) begin
         x            = 9'($urandom_range(0, 335));
         y            = 8'($urandom_range(0, 250));
         colour       = 3'($urandom);
         plot         = ($urandom_range(0, 2) == 0);
         clear        = ($urandom_range(0, 149) == 0);
         clear_colour = 3'($urandom);
         mem_ready    = ($urandom_range(0, 3) != 0);
         reset        = (sweeping && pos > 250) ? 1'b1 : ($urandom_range(0, 999) == 0);
         tick();
      end
      plot = 1'b0; clear = 1'b0; reset = 1'b0; mem_ready = 1'b1;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface that line/shape drawers drive: x, y, colour and a one-cycle plot strobe, with no backpressure.
- Validates each coordinate, buffers accepted commands in a small FIFO, and converts each one to a linear framebuffer address.
- Issues writes to the framebuffer RAM write port through a valid/ready handshake.
- Also runs a full-screen clear sweep on request. It sits between the drawing FSMs and the video memory.

Parameters:
- WIDTH, 320, horizontal resolution in pixels.
- HEIGHT, 240, vertical resolution in pixels.
- COLOUR_BITS, 3, colour word width.
- FIFO_DEPTH, 4, command buffer entries; must be a power of two.
- ADDR_BITS, 17, framebuffer address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  9  pixel column.
- y  in  8  pixel row.
- colour  in  COLOUR_BITS  pixel colour.
- plot  in  1  one-cycle strobe; x, y and colour are sampled in the same cycle.
- clear  in  1  one-cycle request to start the clear sweep.
- clear_colour  in  COLOUR_BITS  fill colour, sampled when clear is accepted.
- mem_addr  out  ADDR_BITS  write address.
- mem_data  out  COLOUR_BITS  write data.
- mem_valid  out  1  write request.
- mem_ready  in  1  memory accepts the write when mem_valid && mem_ready.
- busy  out  1  high when the FIFO is non-empty or a clear is in progress.
- overflow  out  1  sticky flag: a valid plot was lost because the FIFO was full.
- dropped_cnt  out  8  saturating count of plots rejected for out-of-range coordinates.

Behaviour:
- Reset (reset=1 at a clock edge):
  - FIFO emptied; state goes to IDLE.
  - mem_valid=0, mem_addr=0, mem_data=0, busy=0, overflow=0, dropped_cnt=0.
  - A reset in the middle of a clear or drain aborts it immediately; no further writes are issued.
- Plot acceptance:
  - A plot is in range when x<WIDTH and y<HEIGHT.
  - In range: the command is pushed into the FIFO in the same cycle.
  - Out of range: the command is discarded and dropped_cnt increments, saturating at 255.
  - Plot with FIFO full and no pop in that cycle: the command is lost and overflow is set to 1.
  - Plot with FIFO full and a pop in the same cycle: the command is accepted (push and pop coexist).
- Address: addr = y*WIDTH + x. With the defaults this is (y<<8)+(y<<6)+x; no multiplier is used. The result is zero-extended to ADDR_BITS.
- Output register:
  - mem_addr, mem_data and mem_valid are registered.
  - A command pushed at cycle N appears on the memory port at the earliest at N+1 (FIFO empty, port idle).
  - mem_addr, mem_data and mem_valid hold stable while mem_valid=1 and mem_ready=0.
  - The next entry is popped in the cycle the current write handshakes, giving one write per cycle at sustained throughput.
- FSM states:
  - IDLE: FIFO empty, no write outstanding. clear → CLEAR. FIFO non-empty → DRAIN.
  - DRAIN: present FIFO entries. When the FIFO is empty and the last write has handshaked → IDLE. A clear seen in DRAIN is latched as pending; CLEAR starts after the in-flight write completes, and FIFO entries still buffered at that point are drained after the sweep.
  - CLEAR: sweep counter runs from 0 to WIDTH*HEIGHT-1, one address per handshake, data = latched clear_colour. Plots arriving during CLEAR are still validated and buffered (the overflow rules above apply). After the final address handshakes: FIFO non-empty → DRAIN, otherwise IDLE.
  - A clear arriving while already in CLEAR is ignored.
- Priority: a clear accepted in IDLE in the same cycle as a plot enters CLEAR; the plot is buffered and written after the sweep.
- busy = (state != IDLE) || fifo_count != 0 || clear_pending.

Decomposition:
- Package plot_sink_pkg:
  - state encoding (IDLE, DRAIN, CLEAR);
  - the FIFO entry struct {addr, colour};
  - constants SCREEN_PIXELS = WIDTH*HEIGHT and LAST_ADDR.
- One sub-module: plot_fifo, a parameterised synchronous FIFO.
  - Ports: push, pop, din, dout, full, empty, count.
  - Push and pop are allowed in the same cycle when full.
- Address computation and the FSM stay in the top module.

Test Plan:
- Single plot (x=5, y=2, colour=3'b101), mem_ready=1 → exactly one write with mem_addr=645, mem_data=5 one cycle after plot; busy returns to 0 on the following cycle.
- Out-of-range plots x=320,y=0 and x=0,y=240 → no writes; dropped_cnt=2; overflow stays 0.
- mem_ready held 0, then 6 consecutive valid plots → first 4 buffered (FIFO_DEPTH=4), later ones lost, overflow=1. mem_addr/mem_data stay stable while stalled. Raise mem_ready → the 4 buffered commands are written in order.
- clear with clear_colour=3'b000, mem_ready=1 → 76800 writes with addresses 0..76799 in order, every mem_data=0; busy high throughout.
- Plot (x=319, y=239) issued mid-clear → buffered and written to address 76799 with the plot colour after the sweep completes.
- reset asserted at sweep address 1000 → mem_valid=0 on the next cycle and all outputs at their reset values; no further writes appear.
